// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative 32x32 multiply / restoring divide unit, one iteration per cycle.
// MULT_DIV_SIGNED_EN enables signed MULT/DIV; undefined builds treat every op as unsigned.
module mult_div (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divZero
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state;
  state_t      nextState;
  logic [63:0] work;
  logic [31:0] opB;
  logic [4:0]  iter;
  logic        accept;
  logic [63:0] mulNext;
  logic [63:0] divNext;
  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic [33:0] divDiff;
  logic        divGe;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] resHi;
  logic [31:0] resLo;
  logic [31:0] zeroHi;

`ifdef MULT_DIV_SIGNED_EN
  logic        signedOp;
  logic        isDiv;
  logic        negQ;
  logic        negR;
  logic [63:0] negProd;

  assign signedOp = op[0];
  assign absA     = (signedOp && srcA[31]) ? -srcA : srcA;
  assign absB     = (signedOp && srcB[31]) ? -srcB : srcB;
  assign negProd  = -work;

  // Magnitudes are iterated; signs are reapplied once in FIX.
  always_comb begin
    resHi  = work[63:32];
    resLo  = work[31:0];
    zeroHi = negR ? -work[31:0] : work[31:0];
    if (isDiv) begin
      resLo = negQ ? -work[31:0] : work[31:0];
      resHi = negR ? -work[63:32] : work[63:32];
    end else if (negQ) begin
      resHi = negProd[63:32];
      resLo = negProd[31:0];
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      isDiv <= 1'b0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
    end else if (accept) begin
      isDiv <= op[1];
      negQ  <= signedOp && (srcA[31] ^ srcB[31]);
      negR  <= signedOp && srcA[31];
    end
  end
`else
  logic unusedOp0;

  assign unusedOp0 = op[0];
  assign absA      = srcA;
  assign absB      = srcB;

  always_comb begin
    resHi  = work[63:32];
    resLo  = work[31:0];
    zeroHi = work[31:0];
  end
`endif

  assign accept = start && ((state == IDLE) || (state == DONE));

  // Shift-add: multiplier bits come from the low half and shift out as the product shifts in.
  assign mulSum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opB} : 33'd0);
  assign mulNext = {mulSum, work[31:1]};

  // Restoring divide: high half is the partial remainder, low half collects quotient bits.
  assign divShift = work[63:31];
  assign divDiff  = {1'b0, divShift} - {2'b00, opB};
  assign divGe    = ~divDiff[33];
  assign divNext  = {(divGe ? divDiff[31:0] : divShift[31:0]), work[30:0], divGe};

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nextState = op[1] ? DIV : MUL;
        end else begin
          nextState = IDLE;
        end
      end
      MUL:     nextState = (iter == 5'd31) ? FIX : MUL;
      DIV: begin
        if (opB == 32'd0) begin
          nextState = DONE;
        end else if (iter == 5'd31) begin
          nextState = FIX;
        end else begin
          nextState = DIV;
        end
      end
      FIX:     nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      MUL, DIV, FIX: busy = 1'b1;
      DONE:          done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      work    <= 64'd0;
      opB     <= 32'd0;
      iter    <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      divZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work    <= {32'd0, absA};
            opB     <= absB;
            iter    <= 5'd0;
            divZero <= 1'b0;
          end
        end
        MUL: begin
          work <= mulNext;
          iter <= iter + 5'd1;
        end
        DIV: begin
          if (opB == 32'd0) begin
            hi      <= zeroHi;
            lo      <= 32'hFFFF_FFFF;
            divZero <= 1'b1;
          end else begin
            work <= divNext;
            iter <= iter + 5'd1;
          end
        end
        FIX: begin
          hi <= resHi;
          lo <= resLo;
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - randomized self-checking bench for mult_div against an arithmetic model.
// Honours MULT_DIV_SIGNED_EN the same way as the design.
module tb_mult_div;

`ifdef MULT_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clock_in;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divZero;

  int errors = 0;
  int checks = 0;

  mult_div dut (
    .clock_in(clock_in),
    .reset(reset),
    .start(start),
    .op(op),
    .srcA(srcA),
    .srcB(srcB),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .divZero(divZero)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic edz, output int elat);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    bit sgn;
    sgn  = SIGNED_EN && o[0];
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    edz  = 1'b0;
    elat = 33;
    if (!o[1]) begin
      if (sgn) p = sa * sb;
      else     p = {32'd0, a} * {32'd0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh   = a;
      el   = 32'hFFFF_FFFF;
      edz  = 1'b1;
      elat = 1;
    end else if (sgn) begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endtask

  // Drives one operation from an idle or DONE cycle; scrambles inputs after acceptance.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] h, output logic [31:0] l,
                       output logic dz, output logic busyBad);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    step();
    start   = 1'b0;
    op      = 2'($urandom);
    srcA    = $urandom;
    srcB    = $urandom;
    lat     = 0;
    busyBad = 1'b0;
    while (!done && lat < 40) begin
      if (!busy) busyBad = 1'b1;
      step();
      lat++;
    end
    if (busy) busyBad = 1'b1;
    h  = hi;
    l  = lo;
    dz = divZero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    srcA  = 32'd0;
    srcB  = 32'd0;
    step();
    step();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'd0)      begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0)      begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (divZero !== 1'b0)  begin errors++; $display("FAIL reset_divZero got %b want 0", divZero); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [1:0]  vOp [6];
    logic [31:0] vA [6];
    logic [31:0] vB [6];
    logic [31:0] vHi [6];
    logic [31:0] vLo [6];
    logic        vDz [6];
    int          vLat [6];
    int          lat;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    logic        bb;
    vOp[0] = 2'b00; vA[0] = 32'hFFFF0000; vB[0] = 32'h0000FFFF; vHi[0] = 32'h0000FFFE; vLo[0] = 32'h00010000;
    vOp[1] = 2'b01; vA[1] = 32'hFFFFFFFD; vB[1] = 32'd7;        vLo[1] = 32'hFFFFFFEB;
    vOp[2] = 2'b10; vA[2] = 32'd100;      vB[2] = 32'd7;        vHi[2] = 32'd2;         vLo[2] = 32'd14;
    vOp[3] = 2'b11; vA[3] = 32'hFFFFFFF9; vB[3] = 32'd2;
    vOp[4] = 2'b11; vA[4] = 32'h80000000; vB[4] = 32'hFFFFFFFF;
    vOp[5] = 2'b11; vA[5] = 32'd5;        vB[5] = 32'd0;        vHi[5] = 32'd5;         vLo[5] = 32'hFFFFFFFF;
`ifdef MULT_DIV_SIGNED_EN
    vHi[1] = 32'hFFFFFFFF;
    vHi[3] = 32'hFFFFFFFF; vLo[3] = 32'hFFFFFFFD;
    vHi[4] = 32'h00000000; vLo[4] = 32'h80000000;
`else
    vHi[1] = 32'h00000006;
    vHi[3] = 32'h00000001; vLo[3] = 32'h7FFFFFFC;
    vHi[4] = 32'h80000000; vLo[4] = 32'h00000000;
`endif
    for (int i = 0; i < 6; i++) begin
      vDz[i]  = (i == 5);
      vLat[i] = (i == 5) ? 1 : 33;
    end
    for (int i = 0; i < 6; i++) begin
      runOp(vOp[i], vA[i], vB[i], lat, h, l, dz, bb);
      checks++; if (h !== vHi[i])    begin errors++; $display("FAIL directed%0d_hi got %h want %h", i, h, vHi[i]); end
      checks++; if (l !== vLo[i])    begin errors++; $display("FAIL directed%0d_lo got %h want %h", i, l, vLo[i]); end
      checks++; if (dz !== vDz[i])   begin errors++; $display("FAIL directed%0d_divZero got %b want %b", i, dz, vDz[i]); end
      checks++; if (lat !== vLat[i]) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, vLat[i]); end
      checks++; if (bb !== 1'b0)     begin errors++; $display("FAIL directed%0d_busy got bad want clean", i); end
      step();
    end
    // divZero from the last vector must hold while idle.
    checks++; if (divZero !== 1'b1) begin errors++; $display("FAIL divZero_hold got %b want 1", divZero); end
  endtask

  task automatic test_random();
    logic [31:0] edge_vals [4];
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    int          elat;
    int          lat;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    logic        bb;
    edge_vals[0] = 32'h00000000;
    edge_vals[1] = 32'h80000000;
    edge_vals[2] = 32'hFFFFFFFF;
    edge_vals[3] = 32'h00000001;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      model(o, a, b, eh, el, edz, elat);
      runOp(o, a, b, lat, h, l, dz, bb);
      checks++;
      if (h !== eh || l !== el || dz !== edz || lat !== elat || bb !== 1'b0) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h got hi=%h lo=%h dz=%b lat=%0d bb=%b want hi=%h lo=%h dz=%b lat=%0d",
                 i, o, a, b, h, l, dz, lat, bb, eh, el, edz, elat);
      end
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

  task automatic test_start_ignored();
    int lat;
    start = 1'b1;
    op    = 2'b00;
    srcA  = 32'hFFFF0000;
    srcB  = 32'h0000FFFF;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    start = 1'b1;
    op    = 2'b10;
    srcA  = 32'd9;
    srcB  = 32'd0;
    step();
    start = 1'b0;
    lat   = 10;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    checks++; if (lat !== 33)           begin errors++; $display("FAIL ignored_latency got %0d want 33", lat); end
    checks++; if (hi !== 32'h0000FFFE)  begin errors++; $display("FAIL ignored_hi got %h want 0000fffe", hi); end
    checks++; if (lo !== 32'h00010000)  begin errors++; $display("FAIL ignored_lo got %h want 00010000", lo); end
    checks++; if (divZero !== 1'b0)     begin errors++; $display("FAIL ignored_divZero got %b want 0", divZero); end
    step();
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    logic        bb;
    runOp(2'b10, 32'd77, 32'd0, lat, h, l, dz, bb);
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL b2b_divZero_set got %b want 1", dz); end
    // Still in DONE: this start is accepted immediately and must clear divZero.
    runOp(2'b10, 32'd1000, 32'd33, lat, h, l, dz, bb);
    checks++; if (bb !== 1'b0)     begin errors++; $display("FAIL b2b_busy got bad want clean"); end
    checks++; if (lat !== 33)      begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (l !== 32'd30)    begin errors++; $display("FAIL b2b_lo got %0d want 30", l); end
    checks++; if (h !== 32'd10)    begin errors++; $display("FAIL b2b_hi got %0d want 10", h); end
    checks++; if (dz !== 1'b0)     begin errors++; $display("FAIL b2b_divZero_clear got %b want 0", dz); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_reset_abort();
    logic sawDone;
    start = 1'b1;
    op    = 2'b10;
    srcA  = 32'd123456;
    srcB  = 32'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0)     begin errors++; $display("FAIL abort_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0)     begin errors++; $display("FAIL abort_lo got %h want 0", lo); end
    checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL abort_divZero got %b want 0", divZero); end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) sawDone = 1'b1;
      step();
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("FAIL abort_done got pulse want none"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
